aes128_iter_core: RTL and testbench

//  Parametrised iterative AES-128 encryption core; successor to the single-round-per-cycle top.

---
 rtl/aes128_iter_core.sv | 194 +++++++++++++++++++
 tb/tb_aes128_iter_core.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_iter_core.sv
// AES-128 encryption core, UNROLL rounds per clock, ready/valid on both sides.
// Ports: clk/rst (sync, active-high); anahtar/blok/g_tag + g_gecerli/hazir in;
//        sifre/c_tag + c_gecerli/c_hazir out; tur = current round (debug).
module aes128_iter_core #(
    parameter int UNROLL = 1,
    parameter int TAG_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [127:0]     anahtar,
    input  logic [127:0]     blok,
    input  logic [TAG_W-1:0] g_tag,
    input  logic             g_gecerli,
    output logic             hazir,
    output logic [127:0]     sifre,
    output logic [TAG_W-1:0] c_tag,
    output logic             c_gecerli,
    input  logic             c_hazir,
    output logic [3:0]       tur
);
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
        $error("aes128_iter_core: UNROLL must be 1, 2, 5 or 10");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box = affine(a^254); a^254 = a^2*a^4*...*a^128, and 0 maps to 0.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]) ^ rcon(r), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Byte n of the state is s[127-8n -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   b  [16];
        logic [7:0]   sh [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sh[4*c+r] = b[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            a0 = sh[4*c];
            a1 = sh[4*c+1];
            a2 = sh[4*c+2];
            a3 = sh[4*c+3];
            if (last) begin
                o[127-32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                     xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
            end
        end
        return o ^ k;
    endfunction

    state_e           state_q, state_d;
    logic [127:0]     st_q, st_d;
    logic [127:0]     rk_q, rk_d;
    logic [127:0]     sifre_q, sifre_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TAG_W-1:0] c_tag_q, c_tag_d;
    logic [3:0]       tur_q, tur_d;
    logic [127:0]     st_c, rk_c;
    logic [3:0]       r_c;

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rk_d    = rk_q;
        sifre_d = sifre_q;
        tag_d   = tag_q;
        c_tag_d = c_tag_q;
        tur_d   = tur_q;
        st_c    = st_q;
        rk_c    = rk_q;
        r_c     = tur_q;
        // Round chain; r_c leaves the loop as tur_q + UNROLL.
        for (int i = 0; i < UNROLL; i++) begin
            rk_c = key_step(rk_c, r_c);
            st_c = aes_round(st_c, rk_c, r_c == 4'd10);
            r_c  = r_c + 4'd1;
        end
        unique case (state_q)
            IDLE: begin
                if (g_gecerli) begin
                    state_d = RUN;
                    st_d    = anahtar ^ blok;
                    rk_d    = anahtar;
                    tag_d   = g_tag;
                    tur_d   = 4'd1;
                end
            end
            RUN: begin
                st_d  = st_c;
                rk_d  = rk_c;
                tur_d = r_c;
                if (r_c == 4'd11) begin
                    state_d = DONE;
                    tur_d   = 4'd0;
                    sifre_d = st_c;
                    c_tag_d = tag_q;
                end
            end
            DONE: begin
                if (c_hazir) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            st_q    <= '0;
            rk_q    <= '0;
            sifre_q <= '0;
            tag_q   <= '0;
            c_tag_q <= '0;
            tur_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            sifre_q <= sifre_d;
            tag_q   <= tag_d;
            c_tag_q <= c_tag_d;
            tur_q   <= tur_d;
        end
    end

    assign hazir     = (state_q == IDLE);
    assign c_gecerli = (state_q == DONE);
    assign sifre     = sifre_q;
    assign c_tag     = c_tag_q;
    assign tur       = tur_q;
endmodule

// File: tb/tb_aes128_iter_core.sv
// Bench for aes128_iter_core: four instances (UNROLL 1,2,5,10) checked
// against known vectors and a byte-array AES reference model.
module tb_aes128_iter_core;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] anahtar   [4];
    logic [127:0] blok      [4];
    logic [7:0]   g_tag     [4];
    logic         g_gecerli [4];
    logic         hazir     [4];
    logic [127:0] sifre     [4];
    logic [7:0]   c_tag     [4];
    logic         c_gecerli [4];
    logic         c_hazir   [4];
    logic [3:0]   tur       [4];

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] sb [256];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        localparam int U = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 5 : 10;
        aes128_iter_core #(.UNROLL(U), .TAG_W(8)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .anahtar   (anahtar[k]),
            .blok      (blok[k]),
            .g_tag     (g_tag[k]),
            .g_gecerli (g_gecerli[k]),
            .hazir     (hazir[k]),
            .sifre     (sifre[k]),
            .c_tag     (c_tag[k]),
            .c_gecerli (c_gecerli[k]),
            .c_hazir   (c_hazir[k]),
            .tur       (tur[k])
        );
    end

    function automatic int un(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 5 : 10;
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] x;
        logic [7:0] p;
        p = 8'h00;
        x = {1'b0, a};
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x[7:0];
            x = x << 1;
            if (x[8]) x = x ^ 9'h11b;
        end
        return p;
    endfunction

    // S-box by brute-force inverse search and the bitwise affine formula.
    task automatic build_sbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8]
                     ^ inv[(i+7)%8] ^ c[i];
            sb[x] = s;
        end
    endtask

    function automatic logic [127:0] ref_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   w   [176];
        logic [7:0]   s   [16];
        logic [7:0]   t   [16];
        logic [7:0]   tmp [4];
        logic [7:0]   u, rc;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) w[i] = key[127-8*i -: 8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
            if (i % 4 == 0) begin
                u      = tmp[0];
                tmp[0] = sb[tmp[1]] ^ rc;
                tmp[1] = sb[tmp[2]];
                tmp[2] = sb[tmp[3]];
                tmp[3] = sb[u];
                rc     = gm(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    t[4*c+q] = s[4*((c+q)%4)+q];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    if (r < 10)
                        s[4*c+q] = gm(t[4*c+q], 8'h02) ^ gm(t[4*c+(q+1)%4], 8'h03)
                                 ^ t[4*c+(q+2)%4] ^ t[4*c+(q+3)%4];
                    else
                        s[4*c+q] = t[4*c+q];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    // One block through instance k from IDLE, then a single-cycle transfer.
    task automatic run_vec(input int k, input logic [127:0] key, input logic [127:0] pt,
                           input logic [7:0] tg, input logic [127:0] exp);
        int n;
        chk($sformatf("idle_rdy_u%0d", un(k)), 128'(hazir[k]), 128'd1);
        anahtar[k]   = key;
        blok[k]      = pt;
        g_tag[k]     = tg;
        g_gecerli[k] = 1'b1;
        cyc1();
        g_gecerli[k] = 1'b0;
        anahtar[k]   = rnd128();
        blok[k]      = rnd128();
        g_tag[k]     = 8'($urandom);
        chk($sformatf("tur_start_u%0d", un(k)), 128'(tur[k]), 128'd1);
        n = 0;
        while (!c_gecerli[k] && n < 40) begin
            cyc1();
            n++;
        end
        chk($sformatf("latency_u%0d", un(k)), 128'(n), 128'(10 / un(k)));
        chk($sformatf("ct_u%0d", un(k)), sifre[k], exp);
        chk($sformatf("tag_u%0d", un(k)), 128'(c_tag[k]), 128'(tg));
        chk($sformatf("tur_done_u%0d", un(k)), 128'(tur[k]), 128'd0);
        c_hazir[k] = 1'b1;
        cyc1();
        c_hazir[k] = 1'b0;
        chk($sformatf("vld_drop_u%0d", un(k)), 128'(c_gecerli[k]), 128'd0);
        chk($sformatf("rdy_back_u%0d", un(k)), 128'(hazir[k]), 128'd1);
        chk($sformatf("ct_kept_u%0d", un(k)), sifre[k], exp);
    endtask

    task automatic b2b(input int k);
        logic [127:0] q_ct [$];
        logic [7:0]   q_tg [$];
        int n_acc, n_rx, last, cyc;
        n_acc = 0;
        n_rx  = 0;
        last  = -1;
        cyc   = 0;
        c_hazir[k] = 1'b1;
        while (n_rx < 20 && cyc < 600) begin
            if (n_acc < 20) begin
                g_gecerli[k] = 1'b1;
                anahtar[k]   = rnd128();
                blok[k]      = rnd128();
                g_tag[k]     = 8'($urandom);
                if (hazir[k]) begin
                    q_ct.push_back(ref_enc(anahtar[k], blok[k]));
                    q_tg.push_back(g_tag[k]);
                    if (last >= 0)
                        chk($sformatf("period_u%0d", un(k)), 128'(cyc - last),
                            128'(10 / un(k) + 2));
                    last = cyc;
                    n_acc++;
                end
            end else begin
                g_gecerli[k] = 1'b0;
            end
            cyc1();
            cyc++;
            if (c_gecerli[k]) begin
                if (q_ct.size() > 0) begin
                    chk($sformatf("b2b_ct_u%0d_%0d", un(k), n_rx), sifre[k], q_ct.pop_front());
                    chk($sformatf("b2b_tag_u%0d_%0d", un(k), n_rx), 128'(c_tag[k]),
                        128'(q_tg.pop_front()));
                end else begin
                    chk($sformatf("b2b_spurious_u%0d", un(k)), 128'(c_gecerli[k]), 128'd0);
                end
                n_rx++;
            end
        end
        chk($sformatf("b2b_count_u%0d", un(k)), 128'(n_rx), 128'd20);
        g_gecerli[k] = 1'b0;
        c_hazir[k]   = 1'b0;
        cyc1();
    endtask

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin
        logic [127:0] exp_ct, held;
        logic [7:0]   held_tag;
        int n;
        for (int k = 0; k < 4; k++) begin
            anahtar[k]   = '0;
            blok[k]      = '0;
            g_tag[k]     = '0;
            g_gecerli[k] = 1'b0;
            c_hazir[k]   = 1'b0;
        end
        build_sbox();
        chk("model_fips", ref_enc(K1, P1), C1);

        // Reset state
        rst = 1'b1;
        cyc1();
        cyc1();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_rdy_u%0d", un(k)), 128'(hazir[k]), 128'd1);
            chk($sformatf("rst_vld_u%0d", un(k)), 128'(c_gecerli[k]), 128'd0);
            chk($sformatf("rst_ct_u%0d", un(k)), sifre[k], 128'd0);
            chk($sformatf("rst_tag_u%0d", un(k)), 128'(c_tag[k]), 128'd0);
            chk($sformatf("rst_tur_u%0d", un(k)), 128'(tur[k]), 128'd0);
        end
        rst = 1'b0;
        cyc1();

        // Known-answer vectors on every unroll factor
        for (int k = 0; k < 4; k++) begin
            run_vec(k, K1, P1, 8'h5a, C1);
            run_vec(k, K2, P2, 8'hc3, C2);
        end

        // Back-pressure on UNROLL=1
        anahtar[0]   = rnd128();
        blok[0]      = rnd128();
        g_tag[0]     = 8'h77;
        exp_ct       = ref_enc(anahtar[0], blok[0]);
        g_gecerli[0] = 1'b1;
        cyc1();
        g_gecerli[0] = 1'b0;
        n = 0;
        while (!c_gecerli[0] && n < 40) begin
            cyc1();
            n++;
        end
        chk("bp_latency", 128'(n), 128'd10);
        chk("bp_ct", sifre[0], exp_ct);
        held         = sifre[0];
        held_tag     = c_tag[0];
        g_gecerli[0] = 1'b1;
        anahtar[0]   = rnd128();
        blok[0]      = rnd128();
        for (int i = 0; i < 7; i++) begin
            cyc1();
            chk($sformatf("bp_hold_ct_%0d", i), sifre[0], held);
            chk($sformatf("bp_hold_tag_%0d", i), 128'(c_tag[0]), 128'(held_tag));
            chk($sformatf("bp_hold_vld_%0d", i), 128'(c_gecerli[0]), 128'd1);
            chk($sformatf("bp_hold_rdy_%0d", i), 128'(hazir[0]), 128'd0);
        end
        g_gecerli[0] = 1'b0;
        c_hazir[0]   = 1'b1;
        cyc1();
        c_hazir[0] = 1'b0;
        chk("bp_release_vld", 128'(c_gecerli[0]), 128'd0);
        chk("bp_release_rdy", 128'(hazir[0]), 128'd1);
        cyc1();
        chk("bp_no_accept_tur", 128'(tur[0]), 128'd0);
        chk("bp_no_accept_rdy", 128'(hazir[0]), 128'd1);

        // Reset in the middle of a block
        anahtar[0]   = K1;
        blok[0]      = P1;
        g_tag[0]     = 8'h5a;
        g_gecerli[0] = 1'b1;
        cyc1();
        g_gecerli[0] = 1'b0;
        n = 0;
        while (tur[0] != 4'd4 && n < 20) begin
            cyc1();
            n++;
        end
        chk("abort_tur4", 128'(tur[0]), 128'd4);
        rst = 1'b1;
        cyc1();
        rst = 1'b0;
        chk("abort_rdy", 128'(hazir[0]), 128'd1);
        chk("abort_vld", 128'(c_gecerli[0]), 128'd0);
        chk("abort_ct", sifre[0], 128'd0);
        chk("abort_tur", 128'(tur[0]), 128'd0);
        run_vec(0, K2, P2, 8'h3c, C2);

        // Back-to-back random blocks
        for (int k = 0; k < 4; k++) b2b(k);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
